// File: rtl/count_checker_if.sv
// Observed generator stream plus the shared generator controls, as seen by the checker.
interface count_checker_if #(
    parameter int unsigned COUNT_WIDTH = 4
) ();

    logic                   clk_enable;
    logic                   start;
    logic                   auto_start;
    logic [COUNT_WIDTH-1:0] in;
    logic                   in_last;

    // Generator side (or a bench standing in for it) drives the stream.
    modport master (
        output clk_enable,
        output start,
        output auto_start,
        output in,
        output in_last
    );

    // Checker side only observes.
    modport slave (
        input clk_enable,
        input start,
        input auto_start,
        input in,
        input in_last
    );

endinterface

// File: rtl/count_checker.sv
// count_checker: cycle-exact expected-value model of the count sequence generator,
// compared against the observed stream on every enabled tick. Counts mismatches and
// completed sequences, captures the first error and resynchronises on a sequence end.
module count_checker #(
    parameter int unsigned             COUNT_WIDTH   = 4,
    parameter logic [COUNT_WIDTH-1:0]  COUNT_START   = '0,
    parameter logic [COUNT_WIDTH-1:0]  COUNT_END     = COUNT_WIDTH'(15),
    parameter logic [COUNT_WIDTH-1:0]  COUNT_INCR    = COUNT_WIDTH'(1),
    parameter int unsigned             ERR_CNT_WIDTH = 8,
    parameter int unsigned             SEQ_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    count_checker_if.slave           mon,
    input  logic                     clear,
    output logic                     err_pulse,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     seq_done,
    output logic [SEQ_CNT_WIDTH-1:0] seq_count,
    output logic [COUNT_WIDTH-1:0]   first_err_exp,
    output logic [COUNT_WIDTH-1:0]   first_err_got,
    output logic                     resync
);

    typedef enum logic [1:0] {StInit, StIdle, StCounting, StResync} state_e;

    state_e                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   exp_out_q, exp_out_d;
    logic                     exp_last_q, exp_last_d;

    logic                     err_pulse_q, err_pulse_d;
    logic                     err_sticky_q, err_sticky_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     seq_done_q, seq_done_d;
    logic [SEQ_CNT_WIDTH-1:0] seq_count_q, seq_count_d;
    logic [COUNT_WIDTH-1:0]   fe_exp_q, fe_exp_d;
    logic [COUNT_WIDTH-1:0]   fe_got_q, fe_got_d;

    logic                     mismatch;
    logic                     checking;
    logic                     err_event;
    logic                     done_event;
    logic [COUNT_WIDTH-1:0]   nxt_out;
    logic                     do_load;
    logic                     load_trig;
    logic [ERR_CNT_WIDTH-1:0] err_base;
    logic [SEQ_CNT_WIDTH-1:0] seq_base;
    logic                     sticky_base;

    assign mismatch   = (mon.in != exp_out_q) || (mon.in_last != exp_last_q);
    // Comparisons are suspended while waiting for the generator's sequence end.
    assign checking   = mon.clk_enable && (state_q != StResync);
    assign err_event  = checking && mismatch;
    assign done_event = checking && !mismatch && mon.in_last;
    assign nxt_out    = exp_out_q + COUNT_INCR;

    // Next-state and expected-value model, advancing only on enabled ticks.
    always_comb begin
        state_d    = state_q;
        exp_out_d  = exp_out_q;
        exp_last_d = exp_last_q;
        do_load    = 1'b0;
        load_trig  = mon.start;
        if (mon.clk_enable) begin
            if (state_q == StResync) begin
                do_load = mon.in_last;
            end else if (mismatch) begin
                if (mon.in_last) begin
                    // Generator has ended its sequence, so realign as if idle.
                    do_load = 1'b1;
                end else begin
                    exp_out_d  = '0;
                    exp_last_d = 1'b0;
                    state_d    = StResync;
                end
            end else if (state_q == StCounting) begin
                exp_out_d  = nxt_out;
                exp_last_d = (nxt_out == COUNT_END);
                state_d    = (nxt_out == COUNT_END) ? StIdle : StCounting;
            end else begin
                do_load = 1'b1;
                // auto_start only launches the very first sequence after reset.
                if (state_q == StInit) begin
                    load_trig = mon.start || mon.auto_start;
                end
            end
        end
        if (do_load) begin
            if (load_trig) begin
                exp_out_d  = COUNT_START;
                exp_last_d = (COUNT_START == COUNT_END);
                state_d    = (COUNT_START == COUNT_END) ? StIdle : StCounting;
            end else begin
                exp_out_d  = '0;
                exp_last_d = 1'b0;
                state_d    = StIdle;
            end
        end
    end

    // Statistics: clear zeroes first, a same-cycle event then applies on top.
    always_comb begin
        err_base     = clear ? '0 : err_count_q;
        seq_base     = clear ? '0 : seq_count_q;
        sticky_base  = clear ? 1'b0 : err_sticky_q;
        err_count_d  = err_base;
        err_sticky_d = sticky_base;
        fe_exp_d     = clear ? '0 : fe_exp_q;
        fe_got_d     = clear ? '0 : fe_got_q;
        err_pulse_d  = err_event;
        seq_done_d   = done_event;
        seq_count_d  = seq_base + SEQ_CNT_WIDTH'(done_event);
        if (err_event) begin
            err_sticky_d = 1'b1;
            if (err_base != {ERR_CNT_WIDTH{1'b1}}) begin
                err_count_d = err_base + ERR_CNT_WIDTH'(1);
            end
            if (!sticky_base) begin
                fe_exp_d = exp_out_q;
                fe_got_d = mon.in;
            end
        end
    end

    // State and model registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            exp_out_q  <= '0;
            exp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_out_q  <= exp_out_d;
            exp_last_q <= exp_last_d;
        end
    end

    // Statistics and pulse registers; pulses fall on every clock, enabled or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            seq_done_q   <= 1'b0;
            seq_count_q  <= '0;
            fe_exp_q     <= '0;
            fe_got_q     <= '0;
        end else begin
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            seq_done_q   <= seq_done_d;
            seq_count_q  <= seq_count_d;
            fe_exp_q     <= fe_exp_d;
            fe_got_q     <= fe_got_d;
        end
    end

    assign err_pulse     = err_pulse_q;
    assign err_sticky    = err_sticky_q;
    assign err_count     = err_count_q;
    assign seq_done      = seq_done_q;
    assign seq_count     = seq_count_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;
    assign resync        = (state_q == StResync);

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: the bench plays the generator, and a sequence-level model
// (index into the arithmetic sequence, error bookkeeping) predicts every output.
module tb_count_checker;

    localparam int unsigned W = 4;
    localparam logic [3:0] A_START = 4'd2;
    localparam logic [3:0] A_END   = 4'd8;
    localparam logic [3:0] A_INCR  = 4'd2;
    localparam logic [3:0] B_VAL   = 4'd3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic clear   = 1'b0;
    logic clear_b = 1'b0;

    always #5 clk = ~clk;

    count_checker_if #(.COUNT_WIDTH(W)) bus_a ();
    count_checker_if #(.COUNT_WIDTH(W)) bus_b ();

    logic       err_pulse_a, err_sticky_a, seq_done_a, resync_a;
    logic [7:0] err_count_a, seq_count_a;
    logic [3:0] fe_exp_a, fe_got_a;
    logic       err_pulse_c, err_sticky_c, seq_done_c, resync_c;
    logic [1:0] err_count_c;
    logic [7:0] seq_count_c;
    logic [3:0] fe_exp_c, fe_got_c;
    logic       err_pulse_b, err_sticky_b, seq_done_b, resync_b;
    logic [7:0] err_count_b, seq_count_b;
    logic [3:0] fe_exp_b, fe_got_b;

    count_checker #(.COUNT_WIDTH(W), .COUNT_START(A_START), .COUNT_END(A_END),
                    .COUNT_INCR(A_INCR), .ERR_CNT_WIDTH(8), .SEQ_CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .mon(bus_a.slave), .clear(clear),
        .err_pulse(err_pulse_a), .err_sticky(err_sticky_a), .err_count(err_count_a),
        .seq_done(seq_done_a), .seq_count(seq_count_a), .first_err_exp(fe_exp_a),
        .first_err_got(fe_got_a), .resync(resync_a)
    );

    // Same stream as dut_a, narrow error counter to exercise saturation.
    count_checker #(.COUNT_WIDTH(W), .COUNT_START(A_START), .COUNT_END(A_END),
                    .COUNT_INCR(A_INCR), .ERR_CNT_WIDTH(2), .SEQ_CNT_WIDTH(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .mon(bus_a.slave), .clear(clear),
        .err_pulse(err_pulse_c), .err_sticky(err_sticky_c), .err_count(err_count_c),
        .seq_done(seq_done_c), .seq_count(seq_count_c), .first_err_exp(fe_exp_c),
        .first_err_got(fe_got_c), .resync(resync_c)
    );

    count_checker #(.COUNT_WIDTH(W), .COUNT_START(B_VAL), .COUNT_END(B_VAL),
                    .COUNT_INCR(4'd1), .ERR_CNT_WIDTH(8), .SEQ_CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .mon(bus_b.slave), .clear(clear_b),
        .err_pulse(err_pulse_b), .err_sticky(err_sticky_b), .err_count(err_count_b),
        .seq_done(seq_done_b), .seq_count(seq_count_b), .first_err_exp(fe_exp_b),
        .first_err_got(fe_got_b), .resync(resync_b)
    );

    int tests = 0;
    int fails = 0;

    logic [3:0] seqv [16];
    int         n_seq;
    int         m_err_a, m_err_c, m_seq;
    bit         m_sticky;
    logic [3:0] m_fe_exp, m_fe_got;

    task automatic tick_a(input logic en, input logic [3:0] v, input logic l,
                          input logic s, input logic clr);
        bus_a.clk_enable = en;
        bus_a.in         = v;
        bus_a.in_last    = l;
        bus_a.start      = s;
        clear            = clr;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        clear       = 1'b0;
    endtask

    // Disabled ticks: the generator holds its upcoming value; checker must hold too.
    task automatic gap_a(input int mode, input logic [3:0] v, input logic l, inout int bad);
        int   n;
        logic r0;
        r0 = resync_a;
        n  = (mode == 2) ? 2 : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < n; i++) begin
            tick_a(1'b0, v, l, 1'b0, 1'b0);
            if (err_pulse_a || seq_done_a || err_pulse_c || (resync_a !== r0)) bad++;
        end
    endtask

    task automatic model_reset();
        m_err_a  = 0;
        m_err_c  = 0;
        m_seq    = 0;
        m_sticky = 1'b0;
        m_fe_exp = 4'd0;
        m_fe_got = 4'd0;
    endtask

    // One full generator sequence with an optional corruption at index c (-1 = none).
    task automatic test_sequence(input int c, input int forced_bad, input bit clr_at_err,
                                 input int mode);
        int         bad;
        logic [3:0] v, bad_val;
        logic       l;
        bit         exp_e, exp_d, exp_r;
        bad     = 0;
        bad_val = 4'd0;
        gap_a(mode, 4'd0, 1'b0, bad);
        tick_a(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (err_pulse_a !== 1'b0 || seq_done_a !== 1'b0) begin
            fails++;
            $display("FAIL start_edge: got err=%0b done=%0b expected 0/0", err_pulse_a, seq_done_a);
        end
        for (int k = 0; k < n_seq; k++) begin
            v = seqv[k];
            l = (k == n_seq - 1);
            if (k == c) begin
                v = (forced_bad >= 0) ? 4'(forced_bad) : v ^ 4'($urandom_range(1, 15));
                bad_val = v;
            end
            gap_a(mode, v, l, bad);
            tick_a(1'b1, v, l, 1'b0, clr_at_err && (k == c));
            exp_e = (k == c);
            exp_d = (c < 0) && (k == n_seq - 1);
            exp_r = (c >= 0) && (k >= c) && (k < n_seq - 1);
            tests++;
            if (err_pulse_a !== exp_e || err_pulse_c !== exp_e) begin
                fails++;
                $display("FAIL err_pulse k=%0d: got a=%0b c=%0b expected %0b", k, err_pulse_a,
                         err_pulse_c, exp_e);
            end
            tests++;
            if (seq_done_a !== exp_d) begin
                fails++;
                $display("FAIL seq_done k=%0d: got %0b expected %0b", k, seq_done_a, exp_d);
            end
            tests++;
            if (resync_a !== exp_r) begin
                fails++;
                $display("FAIL resync k=%0d: got %0b expected %0b", k, resync_a, exp_r);
            end
        end
        if (clr_at_err && c >= 0) model_reset();
        if (c >= 0) begin
            if (m_err_a < 255) m_err_a++;
            if (m_err_c < 3) m_err_c++;
            if (!m_sticky) begin
                m_sticky = 1'b1;
                m_fe_exp = seqv[c];
                m_fe_got = bad_val;
            end
        end else begin
            m_seq = (m_seq + 1) % 256;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL gap_hold: got %0d bad disabled ticks expected 0", bad);
        end
        tests++;
        if (err_count_a !== 8'(m_err_a) || err_count_c !== 2'(m_err_c)) begin
            fails++;
            $display("FAIL err_count: got a=%0d c=%0d expected a=%0d c=%0d", err_count_a,
                     err_count_c, m_err_a, m_err_c);
        end
        tests++;
        if (err_sticky_a !== m_sticky || err_sticky_c !== m_sticky) begin
            fails++;
            $display("FAIL err_sticky: got %0b expected %0b", err_sticky_a, m_sticky);
        end
        tests++;
        if (fe_exp_a !== m_fe_exp || fe_got_a !== m_fe_got || fe_exp_c !== m_fe_exp) begin
            fails++;
            $display("FAIL first_err: got exp=%0d got=%0d expected exp=%0d got=%0d", fe_exp_a,
                     fe_got_a, m_fe_exp, m_fe_got);
        end
        tests++;
        if (seq_count_a !== 8'(m_seq)) begin
            fails++;
            $display("FAIL seq_count: got %0d expected %0d", seq_count_a, m_seq);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({err_pulse_a, err_sticky_a, err_count_a, seq_done_a, seq_count_a, fe_exp_a,
             fe_got_a, resync_a} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got nonzero output(s) expected all 0");
        end
        tests++;
        if (err_count_c !== 2'd0 || resync_b !== 1'b0 || seq_count_b !== 8'd0) begin
            fails++;
            $display("FAIL reset_others: got c=%0d rb=%0b sb=%0d expected 0", err_count_c,
                     resync_b, seq_count_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clean_sequence();
        test_sequence(-1, -1, 1'b0, 1);
    endtask

    task automatic test_corrupt_sequence();
        test_sequence(1, 5, 1'b0, 0);
        tests++;
        if (fe_exp_a !== 4'd4 || fe_got_a !== 4'd5) begin
            fails++;
            $display("FAIL first_err_value: got exp=%0d got=%0d expected 4/5", fe_exp_a, fe_got_a);
        end
        test_sequence(-1, -1, 1'b0, 0);
    endtask

    task automatic test_enable_gaps();
        test_sequence(-1, -1, 1'b0, 2);
        test_sequence(2, -1, 1'b0, 2);
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 8; i++) begin
            test_sequence(int'($urandom_range(0, n_seq)) - 1, -1, 1'b0,
                          int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_saturation();
        tick_a(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        model_reset();
        tests++;
        if (err_count_a !== 8'd0 || err_sticky_a !== 1'b0 || seq_count_a !== 8'd0) begin
            fails++;
            $display("FAIL clear: got err=%0d sticky=%0b seq=%0d expected 0", err_count_a,
                     err_sticky_a, seq_count_a);
        end
        for (int i = 0; i < 5; i++) test_sequence(int'($urandom_range(0, n_seq - 1)), -1, 1'b0, 0);
        tests++;
        if (err_count_c !== 2'd3 || err_count_a !== 8'd5) begin
            fails++;
            $display("FAIL saturate: got c=%0d a=%0d expected 3/5", err_count_c, err_count_a);
        end
        test_sequence(int'($urandom_range(0, n_seq - 1)), -1, 1'b1, 1);
        tests++;
        if (err_count_c !== 2'd1 || err_count_a !== 8'd1) begin
            fails++;
            $display("FAIL clear_with_err: got c=%0d a=%0d expected 1/1", err_count_c, err_count_a);
        end
    endtask

    // Single-value sequences: generator outputs START/last after each start it sees.
    task automatic test_auto_start();
        logic [3:0] nv;
        logic       nl, s, trig;
        int         mb;
        bit         first;
        nv    = 4'd0;
        nl    = 1'b0;
        mb    = 0;
        first = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            bus_b.clk_enable = 1'b1;
            bus_b.in         = nv;
            bus_b.in_last    = nl;
            bus_b.start      = s;
            @(posedge clk);
            #1;
            tests++;
            if (err_pulse_b !== 1'b0 || seq_done_b !== nl) begin
                fails++;
                $display("FAIL auto_tick %0d: got err=%0b done=%0b expected 0/%0b", i,
                         err_pulse_b, seq_done_b, nl);
            end
            if (nl) mb++;
            trig  = first ? 1'b1 : s;
            first = 1'b0;
            nv    = trig ? B_VAL : 4'd0;
            nl    = trig;
        end
        bus_b.clk_enable = 1'b0;
        tests++;
        if (seq_count_b !== 8'(mb) || err_count_b !== 8'd0) begin
            fails++;
            $display("FAIL auto_counts: got seq=%0d err=%0d expected %0d/0", seq_count_b,
                     err_count_b, mb);
        end
    endtask

    task automatic test_reset_mid();
        tick_a(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        tick_a(1'b1, seqv[0], 1'b0, 1'b0, 1'b0);
        tick_a(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({err_pulse_a, err_sticky_a, err_count_a, seq_count_a, fe_exp_a, fe_got_a,
             resync_a, err_count_c} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got err=%0d sticky=%0b resync=%0b expected 0", err_count_a,
                     err_sticky_a, resync_a);
        end
        #2 rst_n = 1'b1;
        model_reset();
        test_sequence(-1, -1, 1'b0, 1);
    endtask

    initial begin
        logic [3:0] v;
        bus_a.clk_enable = 1'b0;
        bus_a.start      = 1'b0;
        bus_a.auto_start = 1'b0;
        bus_a.in         = 4'd0;
        bus_a.in_last    = 1'b0;
        bus_b.clk_enable = 1'b0;
        bus_b.start      = 1'b0;
        bus_b.auto_start = 1'b1;
        bus_b.in         = 4'd0;
        bus_b.in_last    = 1'b0;
        v     = A_START;
        n_seq = 0;
        for (int i = 0; i < 16; i++) begin
            seqv[i] = v;
            n_seq   = i + 1;
            if (v == A_END) break;
            v = v + A_INCR;
        end
        model_reset();
        test_reset();
        test_clean_sequence();
        test_corrupt_sequence();
        test_enable_gaps();
        test_random_mix();
        test_auto_start();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Receive-side partner of the count sequence generator.
- Taps the generator's out/out_last outputs and the same start, auto_start and clk_enable controls.
- Runs a cycle-exact expected-value model and compares against the observed stream on every enabled tick.
- Reports mismatches, captures the first error, counts errors and completed sequences, and resynchronises after a fault. Used as an on-chip self-check on the icestick designs.

Parameters:
COUNT_WIDTH, 4, width of the observed count
COUNT_START, 0, first value of a sequence (COUNT_WIDTH bits)
COUNT_END, 15, last value of a sequence (COUNT_WIDTH bits)
COUNT_INCR, 1, step per enabled tick (COUNT_WIDTH bits)
ERR_CNT_WIDTH, 8, width of err_count (saturating)
SEQ_CNT_WIDTH, 8, width of seq_count (wrapping)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clk_enable  input  1  tick strobe, shared with the generator
start  input  1  generator start request, same net as the generator's
auto_start  input  1  generator auto-start, same net as the generator's
in  input  COUNT_WIDTH  observed generator out
in_last  input  1  observed generator out_last
clear  input  1  synchronous clear of the statistics
err_pulse  output  1  one-clk pulse per counted mismatch
err_sticky  output  1  set on the first mismatch, held until clear
err_count  output  ERR_CNT_WIDTH  mismatches counted, saturating
seq_done  output  1  one-clk pulse per correctly checked sequence end
seq_count  output  SEQ_CNT_WIDTH  completed sequences, wrapping
first_err_exp  output  COUNT_WIDTH  expected value at the first error
first_err_got  output  COUNT_WIDTH  observed value at the first error
resync  output  1  high while in ST_RESYNC

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0; model exp_out=0, exp_last=0; state ST_INIT.
- Model registers exp_out/exp_last update only on clk_enable edges. They equal the generator's out/out_last at all times when in sync.
- States are ST_INIT, ST_IDLE, ST_COUNTING, ST_RESYNC. clk_enable low: state and model hold; pulses still fall.
- "Load" action:
  - If the trigger is true: exp_out<=COUNT_START, exp_last<=(COUNT_START==COUNT_END), next state ST_IDLE if that equality holds, else ST_COUNTING.
  - Otherwise: exp_out<=0, exp_last<=0, ST_IDLE.
  - Trigger is start||auto_start in ST_INIT; start elsewhere.
- On each enabled edge in ST_INIT, ST_IDLE or ST_COUNTING, evaluate mismatch = (in!=exp_out)||(in_last!=exp_last).
- Match, ST_INIT/ST_IDLE: perform Load.
- Match, ST_COUNTING: nxt=(exp_out+COUNT_INCR) mod 2^COUNT_WIDTH; exp_out<=nxt; exp_last<=(nxt==COUNT_END); next state ST_IDLE if nxt==COUNT_END, else stay.
- Match with in_last=1: seq_done=1 for the next clk cycle; seq_count+1, wrapping.
- Mismatch:
  - err_pulse=1 for one clk; err_count+1, saturating at all-ones; err_sticky<=1.
  - If err_sticky was 0: first_err_exp<=exp_out, first_err_got<=in.
  - If in_last=1: perform the ST_IDLE Load, since the generator has ended its sequence.
  - If in_last=0: exp_out<=0, exp_last<=0, enter ST_RESYNC.
- ST_RESYNC: no comparisons and no counting. On an enabled edge with in_last=1, perform the ST_IDLE Load; otherwise hold. resync=1 in this state.
- clear (synchronous, any clk): zeroes err_count, err_sticky, first_err_exp, first_err_got and seq_count. It does not touch state or the model.
- clear together with an event: the event applies on top of the cleared values (err_count=1 and capture occurs, or seq_count=1).
- Unreachable COUNT_END: the model wraps exactly as the generator does; no error is raised.
- Reset mid-sequence: immediate return to reset values. The generator must be reset in the same cycle to stay aligned.

Test Plan:
- W=4, START=2, END=8, INCR=2; reset; one-tick start pulse; stream 2,4,6,8(last) -> no err_pulse, one seq_done after 8, seq_count=1, err_count=0.
- Same config; corrupt the second value to in=5 -> one err_pulse, err_count=1, first_err_exp=4, first_err_got=5, resync=1. Wrong values 6,8 are not flagged; resync=0 after 8(last). The next start sequence checks clean, seq_count=0 then 1.
- auto_start=1 held from reset, START=END=3 -> first enabled sample expects 3 with in_last=1; seq_done pulses each tick start is held; idle samples 0/0 are not errors.
- clk_enable toggling 1,0,0,1 during a sequence -> compares happen only on enabled edges; pulses are exactly one clk wide.
- ERR_CNT_WIDTH=2; inject 5 mismatches separated by sequence ends -> err_count saturates at 3; first_err fields keep the first error. Assert clear with the 6th error -> err_count=1, new capture.
- rst_n low for a fraction of a cycle mid-sequence -> outputs 0 asynchronously; after release plus start, the check passes.
